// File: rtl/cvw.sv
// Shared configuration package for the STARBUG integer register file.
// The optional same-cycle write-to-read forwarding is selected by the
// STARBUG_RF_BYPASS_EN macro in the register-file files.
package cvw;

  // Core configuration record; the register file uses XLEN and E_SUPPORTED
  typedef struct packed {
    int unsigned XLEN;
    logic        E_SUPPORTED;
  } cvw_t;

  localparam int STARBUG_LANES     = 2;
  localparam int STARBUG_CONFCNT_W = 16;

  localparam cvw_t STARBUG_DEFAULT_CFG = '{XLEN: 32, E_SUPPORTED: 1'b0};

  // A register address is writable/readable when nonzero and present in
  // the configured register count (E mode drops x16..x31).
  function automatic logic rf_addr_legal(input logic [4:0] a, input logic e_mode);
    return (a != 5'd0) && !(e_mode && a[4]);
  endfunction

endpackage

// File: rtl/starbug_rf_bypass.sv
// Read-port filter for the STARBUG register file: applies the x0 and E-mode
// read-as-zero rules and, when STARBUG_RF_BYPASS_EN is defined, forwards
// same-cycle write data (later lanes take precedence).
module starbug_rf_bypass
  import cvw::*;
#(
  parameter cvw_t P = STARBUG_DEFAULT_CFG
) (
  input  logic [4:0]                                  raddr_i,
  input  logic [P.XLEN-1:0]                           arr_i,
  input  logic [STARBUG_LANES-1:0]                    we_i,
  input  logic [STARBUG_LANES-1:0][4:0]               wa_i,
  input  logic [STARBUG_LANES-1:0][P.XLEN-1:0]        wd_i,
  output logic [P.XLEN-1:0]                           rdata_o
);

`ifdef STARBUG_RF_BYPASS_EN
  // Array read, overridden by any matching write; the highest lane wins
  always_comb begin
    rdata_o = '0;
    if (rf_addr_legal(raddr_i, P.E_SUPPORTED)) begin
      rdata_o = arr_i;
      for (int l = 0; l < STARBUG_LANES; l++) begin
        // raddr is legal here, so an equal write address is legal too
        if (we_i[l] && (wa_i[l] == raddr_i)) rdata_o = wd_i[l];
      end
    end
  end
`else
  // Pre-edge array contents only; write ports are not consulted
  always_comb begin
    rdata_o = '0;
    if (rf_addr_legal(raddr_i, P.E_SUPPORTED)) rdata_o = arr_i;
  end

  logic unused_wr_ports;
  assign unused_wr_ports = ^{we_i, wa_i, wd_i};
`endif

endmodule

// File: rtl/starbug_regfile.sv
// Dual-lane STARBUG integer register file: 2R1W per lane, same-cycle
// write-write collision detect (lane 1 wins), saturating collision counter
// and sticky flag. STARBUG_RF_BYPASS_EN enables same-cycle read forwarding.
module starbug_regfile
  import cvw::*;
#(
  parameter cvw_t P = STARBUG_DEFAULT_CFG
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4:0]                    a1_ieu,
  input  logic [4:0]                    a2_ieu,
  output logic [P.XLEN-1:0]             rd1_ieu,
  output logic [P.XLEN-1:0]             rd2_ieu,
  input  logic [4:0]                    a3_ieu,
  input  logic [P.XLEN-1:0]             wd3_ieu,
  input  logic                          we3_ieu,
  input  logic [4:0]                    a1_l1,
  input  logic [4:0]                    a2_l1,
  output logic [P.XLEN-1:0]             rd1_l1,
  output logic [P.XLEN-1:0]             rd2_l1,
  input  logic [4:0]                    a3_l1,
  input  logic [P.XLEN-1:0]             wd3_l1,
  input  logic                          we3_l1,
  input  logic                          ClearConflict,
  output logic                          WriteConflictW,
  output logic                          ConflictSticky,
  output logic [STARBUG_CONFCNT_W-1:0]  ConflictCnt
);

  localparam int NRP = 2 * STARBUG_LANES;

  logic [31:0][P.XLEN-1:0]                   rf_q;
  logic [STARBUG_LANES-1:0]                  we;
  logic [STARBUG_LANES-1:0][4:0]             wa;
  logic [STARBUG_LANES-1:0][P.XLEN-1:0]      wd;
  logic [STARBUG_LANES-1:0]                  wr_ok;
  logic [NRP-1:0][4:0]                       raddr;
  logic [NRP-1:0][P.XLEN-1:0]                rdata;
  logic [STARBUG_CONFCNT_W-1:0]              cnt_q, cnt_d;
  logic                                      sticky_q, sticky_d;

  assign we = {we3_l1, we3_ieu};
  assign wa = {a3_l1,  a3_ieu};
  assign wd = {wd3_l1, wd3_ieu};

  // Collision: both lanes target the same real register; lane 1 is later
  // in bundle order, so lane 0's write is dropped.
  assign WriteConflictW = we3_ieu & we3_l1 & (a3_ieu == a3_l1)
                        & rf_addr_legal(a3_ieu, P.E_SUPPORTED);

  // Per-lane commit qualifiers
  always_comb begin
    wr_ok[0] = we3_ieu & rf_addr_legal(a3_ieu, P.E_SUPPORTED) & ~WriteConflictW;
    wr_ok[1] = we3_l1  & rf_addr_legal(a3_l1,  P.E_SUPPORTED);
  end

  // Register array; reset clears everything and drops same-cycle writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_q <= '0;
    end else begin
      for (int l = 0; l < STARBUG_LANES; l++) begin
        if (wr_ok[l]) rf_q[wa[l]] <= wd[l];
      end
    end
  end

  // Read ports: lane 0 = ports 0/1, lane 1 = ports 2/3
  assign raddr = {a2_l1, a1_l1, a2_ieu, a1_ieu};

  for (genvar i = 0; i < NRP; i++) begin : g_rp
    starbug_rf_bypass #(.P(P)) u_byp (
      .raddr_i (raddr[i]),
      .arr_i   (rf_q[raddr[i]]),
      .we_i    (we),
      .wa_i    (wa),
      .wd_i    (wd),
      .rdata_o (rdata[i])
    );
  end

  assign rd1_ieu = rdata[0];
  assign rd2_ieu = rdata[1];
  assign rd1_l1  = rdata[2];
  assign rd2_l1  = rdata[3];

  // Collision counter / sticky next state; clear restarts from this cycle
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (ClearConflict) begin
      cnt_d    = {{(STARBUG_CONFCNT_W-1){1'b0}}, WriteConflictW};
      sticky_d = WriteConflictW;
    end else if (WriteConflictW) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  // Collision counter / sticky state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign ConflictCnt    = cnt_q;
  assign ConflictSticky = sticky_q;

endmodule
